// File: rtl/vend_seq_ctrl.sv
// ---------------------------------------------------------------------------
// vend_seq_ctrl
//   Vend sequencer for the vending-machine credit datapath. Accepts coin
//   strobes, keeps credit as 3-digit BCD {tens,units,jiao}, serves product
//   selections, holds the dispense request until acknowledged (or timed out),
//   and then pays out change one coin at a time.
//
// Ports
//   CLK, RST       clock; asynchronous active-high reset
//   coin_evt[2:0]  one-cycle coin strobes: [0]=0.5 yuan, [1]=1 yuan, [2]=5 yuan
//   sel_evt[1:0]   one-cycle selection strobes: [0]=product A, [1]=product B
//   cancel         one-cycle refund request
//   dispense_ack   actuator done (only looked at while vending)
//   credit_bcd     current credit, BCD
//   disp_num       {8'h00, credit_bcd, 4'h0} for the display driver
//   vend_a/vend_b  dispense level, held until ack or timeout
//   chg_1y/chg_5j  change-coin eject pulses
//   coin_rej       coin returned, not credited
//   sel_nak        selection refused, insufficient credit
//   fault          vend timeout pulse
//   busy           high whenever not accepting
// ---------------------------------------------------------------------------
module vend_seq_ctrl #(
  parameter logic [11:0] PRICE_A  = 12'h025,
  parameter logic [11:0] PRICE_B  = 12'h030,
  parameter int unsigned CHG_GAP  = 8,
  parameter int unsigned VEND_TMO = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  coin_evt,
  input  logic [1:0]  sel_evt,
  input  logic        cancel,
  input  logic        dispense_ack,
  output logic [11:0] credit_bcd,
  output logic [23:0] disp_num,
  output logic        vend_a,
  output logic        vend_b,
  output logic        chg_1y,
  output logic        chg_5j,
  output logic        coin_rej,
  output logic        sel_nak,
  output logic        fault,
  output logic        busy
);

  localparam int unsigned TW = $clog2(VEND_TMO + 1);
  localparam int unsigned GW = $clog2(CHG_GAP + 1);

  typedef enum logic [1:0] {S_ACCEPT, S_VEND, S_CHANGE} state_t;

  state_t        state_q, state_d;
  logic [11:0]   credit_q, credit_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          vend_a_q, vend_a_d, vend_b_q, vend_b_d;
  logic          chg_1y_q, chg_1y_d, chg_5j_q, chg_5j_d;
  logic          coin_rej_q, coin_rej_d, sel_nak_q, sel_nak_d;
  logic          fault_q, fault_d, busy_q, busy_d;

  // Digit-serial BCD add; bit 12 is the carry out of the tens digit.
  function automatic logic [12:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [4:0]  s;
    logic        c;
    logic [11:0] r;
    c = 1'b0;
    r = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  // Digit-serial BCD subtract; bit 12 set means a < b.
  function automatic logic [12:0] bcd_sub(input logic [11:0] a, input logic [11:0] b);
    logic [4:0]  s;
    logic        bw;
    logic [11:0] r;
    bw = 1'b0;
    r  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      s = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, bw};
      if (s[4]) begin
        s  = s + 5'd10;
        bw = 1'b1;
      end else begin
        bw = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    return {bw, r};
  endfunction

  logic [11:0] coin_val, sel_price, vend_price;
  logic [12:0] coin_sum, sel_diff, refund_sum, chg_diff;
  logic        chg_whole;

  always_comb begin
    coin_val = '0;
    case (coin_evt)
      3'b001:  coin_val = 12'h005;
      3'b010:  coin_val = 12'h010;
      3'b100:  coin_val = 12'h050;
      default: coin_val = '0;
    endcase
    sel_price  = sel_evt[0] ? PRICE_A : PRICE_B;
    vend_price = vend_a_q   ? PRICE_A : PRICE_B;
    chg_whole  = (credit_q[11:4] != 8'h00);
    coin_sum   = bcd_add(credit_q, coin_val);
    sel_diff   = bcd_sub(credit_q, sel_price);
    refund_sum = bcd_add(credit_q, vend_price);
    chg_diff   = bcd_sub(credit_q, chg_whole ? 12'h010 : 12'h005);
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    vend_a_d   = vend_a_q;
    vend_b_d   = vend_b_q;
    chg_1y_d   = 1'b0;
    chg_5j_d   = 1'b0;
    coin_rej_d = 1'b0;
    sel_nak_d  = 1'b0;
    fault_d    = 1'b0;

    case (state_q)
      S_ACCEPT: begin
        if (cancel) begin
          if (credit_q != '0) begin
            state_d = S_CHANGE;
            gap_d   = '0;
          end
        end else if (coin_evt != '0) begin
          if (!$onehot(coin_evt) || coin_sum[12]) coin_rej_d = 1'b1;
          else                                    credit_d   = coin_sum[11:0];
        end else if (sel_evt != '0) begin
          if (!sel_diff[12]) begin
            credit_d = sel_diff[11:0];
            vend_a_d = sel_evt[0];
            vend_b_d = !sel_evt[0];
            state_d  = S_VEND;
            tmo_d    = '0;
          end else begin
            sel_nak_d = 1'b1;
          end
        end
      end

      S_VEND: begin
        coin_rej_d = (coin_evt != '0);
        if (dispense_ack) begin
          vend_a_d = 1'b0;
          vend_b_d = 1'b0;
          state_d  = (credit_q != '0) ? S_CHANGE : S_ACCEPT;
          gap_d    = '0;
        end else if (tmo_q == TW'(VEND_TMO - 1)) begin
          // Undo the sale: the price goes back into credit and is paid out.
          vend_a_d = 1'b0;
          vend_b_d = 1'b0;
          fault_d  = 1'b1;
          credit_d = refund_sum[11:0];
          state_d  = S_CHANGE;
          gap_d    = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_CHANGE: begin
        coin_rej_d = (coin_evt != '0);
        // Leave one cycle after the last pulse, once credit reads zero.
        if (credit_q == '0) begin
          state_d = S_ACCEPT;
        end else if (gap_q == '0) begin
          chg_1y_d = chg_whole;
          chg_5j_d = !chg_whole;
          credit_d = chg_diff[11:0];
          gap_d    = GW'(CHG_GAP - 1);
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      default: state_d = S_ACCEPT;
    endcase

    busy_d = (state_d != S_ACCEPT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_ACCEPT;
      credit_q   <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      vend_a_q   <= 1'b0;
      vend_b_q   <= 1'b0;
      chg_1y_q   <= 1'b0;
      chg_5j_q   <= 1'b0;
      coin_rej_q <= 1'b0;
      sel_nak_q  <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      vend_a_q   <= vend_a_d;
      vend_b_q   <= vend_b_d;
      chg_1y_q   <= chg_1y_d;
      chg_5j_q   <= chg_5j_d;
      coin_rej_q <= coin_rej_d;
      sel_nak_q  <= sel_nak_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
    end
  end

  assign credit_bcd = credit_q;
  assign disp_num   = {8'h00, credit_q, 4'h0};
  assign vend_a     = vend_a_q;
  assign vend_b     = vend_b_q;
  assign chg_1y     = chg_1y_q;
  assign chg_5j     = chg_5j_q;
  assign coin_rej   = coin_rej_q;
  assign sel_nak    = sel_nak_q;
  assign fault      = fault_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_seq_ctrl
//   Directed scenarios followed by random strobes, all compared every cycle
//   against a reference model that counts credit in half-yuan units.
// ---------------------------------------------------------------------------
module tb_vend_seq_ctrl;

  localparam int TMO = 40;
  localparam int GAP = 8;
  localparam int PA  = 5;   // 2.5 yuan in half-yuan units
  localparam int PB  = 6;   // 3.0 yuan
  localparam int MD_ACC  = 0;
  localparam int MD_VEND = 1;
  localparam int MD_CHG  = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  coin_evt = '0;
  logic [1:0]  sel_evt = '0;
  logic        cancel = 1'b0;
  logic        dispense_ack = 1'b0;
  logic [11:0] credit_bcd;
  logic [23:0] disp_num;
  logic        vend_a, vend_b, chg_1y, chg_5j, coin_rej, sel_nak, fault, busy;

  vend_seq_ctrl #(
    .PRICE_A (12'h025),
    .PRICE_B (12'h030),
    .CHG_GAP (GAP),
    .VEND_TMO(TMO)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .coin_evt    (coin_evt),
    .sel_evt     (sel_evt),
    .cancel      (cancel),
    .dispense_ack(dispense_ack),
    .credit_bcd  (credit_bcd),
    .disp_num    (disp_num),
    .vend_a      (vend_a),
    .vend_b      (vend_b),
    .chg_1y      (chg_1y),
    .chg_5j      (chg_5j),
    .coin_rej    (coin_rej),
    .sel_nak     (sel_nak),
    .fault       (fault),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int m_mode, m_credit, m_prod, m_vend_cnt, m_wait;
  logic e_va, e_vb, e_c1, e_c5, e_rej, e_nak, e_flt;

  function automatic logic [11:0] to_bcd(input int h);
    int t, u;
    t = h / 20;
    u = (h % 20) / 2;
    return {4'(t), 4'(u), ((h % 2) != 0) ? 4'h5 : 4'h0};
  endfunction

  task automatic model_reset();
    m_mode = MD_ACC; m_credit = 0; m_prod = 0; m_vend_cnt = 0; m_wait = 0;
    e_va = 0; e_vb = 0; e_c1 = 0; e_c5 = 0; e_rej = 0; e_nak = 0; e_flt = 0;
  endtask

  // What the machine should show after the next clock edge, given these strobes.
  task automatic model_step(input logic [2:0] c, input logic [1:0] s, input logic x, input logic a);
    int v, p;
    e_c1 = 0; e_c5 = 0; e_rej = 0; e_nak = 0; e_flt = 0;
    if (m_mode == MD_ACC) begin
      if (x) begin
        if (m_credit > 0) begin m_mode = MD_CHG; m_wait = 0; end
      end else if (c != 0) begin
        v = c[0] ? 1 : (c[1] ? 2 : 10);
        if ($countones(c) != 1 || m_credit + v > 199) e_rej = 1;
        else m_credit += v;
      end else if (s != 0) begin
        p = s[0] ? PA : PB;
        if (m_credit >= p) begin
          m_credit -= p; m_mode = MD_VEND; m_vend_cnt = 0;
          m_prod = s[0] ? 0 : 1;
          e_va = s[0]; e_vb = !s[0];
        end else e_nak = 1;
      end
    end else begin
      e_rej = (c != 0);
      if (m_mode == MD_VEND) begin
        m_vend_cnt++;
        if (a) begin
          e_va = 0; e_vb = 0;
          m_mode = (m_credit > 0) ? MD_CHG : MD_ACC; m_wait = 0;
        end else if (m_vend_cnt == TMO) begin
          e_va = 0; e_vb = 0; e_flt = 1;
          m_credit += (m_prod == 0) ? PA : PB;
          m_mode = MD_CHG; m_wait = 0;
        end
      end else begin
        if (m_credit == 0) m_mode = MD_ACC;
        else if (m_wait == 0) begin
          if (m_credit >= 2) begin e_c1 = 1; m_credit -= 2; end
          else begin e_c5 = 1; m_credit -= 1; end
          m_wait = GAP - 1;
        end else m_wait--;
      end
    end
  endtask

  task automatic compare_all();
    chk("credit",   32'(credit_bcd), 32'(to_bcd(m_credit)));
    chk("disp_num", 32'(disp_num),   32'({8'h00, to_bcd(m_credit), 4'h0}));
    chk("vend_a",   32'(vend_a),     32'(e_va));
    chk("vend_b",   32'(vend_b),     32'(e_vb));
    chk("chg_1y",   32'(chg_1y),     32'(e_c1));
    chk("chg_5j",   32'(chg_5j),     32'(e_c5));
    chk("coin_rej", 32'(coin_rej),   32'(e_rej));
    chk("sel_nak",  32'(sel_nak),    32'(e_nak));
    chk("fault",    32'(fault),      32'(e_flt));
    chk("busy",     32'(busy),       32'(m_mode != MD_ACC));
  endtask

  // Called just after a falling edge: drive, advance model, check next falling edge.
  task automatic cyc(input logic [2:0] c, input logic [1:0] s, input logic x, input logic a);
    coin_evt = c; sel_evt = s; cancel = x; dispense_ack = a;
    model_step(c, s, x, a);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'b000, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (m_mode != MD_ACC && k < 3000) begin
      cyc(3'b000, 2'b00, 1'b0, 1'b0);
      k++;
    end
    chk("drain_bound", 32'(k < 3000), 32'd1);
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    compare_all();

    // 1) 1y,1y,0.5y then A, then ack with no change due
    cyc(3'b010, 2'b00, 0, 0);
    cyc(3'b010, 2'b00, 0, 0);
    cyc(3'b001, 2'b00, 0, 0);
    chk("t1_credit", 32'(credit_bcd), 32'h025);
    cyc(3'b000, 2'b01, 0, 0);
    chk("t1_vend_a", 32'(vend_a), 32'd1);
    chk("t1_zero",   32'(credit_bcd), 32'h000);
    idle(3);
    cyc(3'b000, 2'b00, 0, 1);
    idle(2);

    // 2) 5y, select B, ack, two 1y change coins
    cyc(3'b100, 2'b00, 0, 0);
    cyc(3'b000, 2'b10, 0, 0);
    chk("t2_vend_b", 32'(vend_b), 32'd1);
    idle(2);
    cyc(3'b000, 2'b00, 0, 1);
    drain();
    chk("t2_busy", 32'(busy), 32'd0);

    // 3) 0.5y x3, refused B, cancel
    for (int i = 0; i < 3; i++) cyc(3'b001, 2'b00, 0, 0);
    chk("t3_credit", 32'(credit_bcd), 32'h015);
    cyc(3'b000, 2'b10, 0, 0);
    chk("t3_nak", 32'(sel_nak), 32'd1);
    cyc(3'b000, 2'b00, 1, 0);
    drain();

    // 4) decimal carry, overflow, multi-hot
    for (int i = 0; i < 9; i++) cyc(3'b010, 2'b00, 0, 0);
    cyc(3'b001, 2'b00, 0, 0);
    cyc(3'b001, 2'b00, 0, 0);
    chk("t4_carry", 32'(credit_bcd), 32'h100);
    for (int i = 0; i < 17; i++) cyc(3'b100, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) cyc(3'b010, 2'b00, 0, 0);
    chk("t4_990", 32'(credit_bcd), 32'h990);
    cyc(3'b010, 2'b00, 0, 0);
    chk("t4_ovf_rej", 32'(coin_rej), 32'd1);
    cyc(3'b011, 2'b00, 0, 0);
    chk("t4_multi_rej", 32'(coin_rej), 32'd1);
    cyc(3'b000, 2'b00, 1, 0);
    drain();

    // 5) timeout refund, coin during change
    for (int i = 0; i < 3; i++) cyc(3'b010, 2'b00, 0, 0);
    cyc(3'b000, 2'b01, 0, 0);
    for (int i = 0; i < TMO + 5; i++) begin
      cyc(3'b000, 2'b00, 0, 0);
      if (m_mode != MD_VEND) break;
    end
    chk("t5_fault",  32'(fault), 32'd1);
    chk("t5_refund", 32'(credit_bcd), 32'h030);
    cyc(3'b010, 2'b00, 0, 0);
    chk("t5_chg_rej", 32'(coin_rej), 32'd1);
    drain();

    // 6) asynchronous reset in the middle of change payout
    cyc(3'b010, 2'b00, 0, 0);
    cyc(3'b010, 2'b00, 0, 0);
    cyc(3'b000, 2'b00, 1, 0);
    cyc(3'b000, 2'b00, 0, 0);
    #2 RST = 1'b1;
    #1;
    chk("rst_credit", 32'(credit_bcd), 32'h000);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_chg",    32'({chg_1y, chg_5j, vend_a, vend_b, fault}), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    compare_all();

    // Random strobes
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] c;
      logic [1:0] s;
      logic x, a;
      c = '0;
      s = '0;
      x = ($urandom_range(0, 29) == 0);
      a = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 9) < 8) c = 3'(1 << $urandom_range(0, 2));
        else c = 3'($urandom_range(3, 7));
      end
      if ($urandom_range(0, 4) == 0) s = 2'($urandom_range(1, 3));
      cyc(c, s, x, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
